// File: rtl/i2s_pkg.sv
`default_nettype none
// i2s_pkg -- shared I2S widths, WS window constants and frame layout helper.  rev 1.0
package i2s_pkg;

  localparam int unsigned I2S_DATA_W   = 24;
  localparam int unsigned I2S_SLOT_W   = 32;
  localparam int unsigned SAMPLE_MAX_W = 32;
  // WS changes this many bit times ahead of the first bit of its slot.
  localparam int unsigned WS_LEAD      = 1;

  // Frame position 0 is the first bit on the wire (left MSB); each sample is
  // MSB-justified in its slot and zero padded.
  function automatic logic frame_bit(
    input logic [SAMPLE_MAX_W-1:0] left,
    input logic [SAMPLE_MAX_W-1:0] right,
    input int unsigned             data_w,
    input int unsigned             slot_w,
    input int unsigned             pos
  );
    logic bit_v;
    bit_v = 1'b0;
    if (pos < data_w) begin
      bit_v = |(left & (SAMPLE_MAX_W'(1) << (data_w - 1 - pos)));
    end else if ((pos >= slot_w) && (pos < slot_w + data_w)) begin
      bit_v = |(right & (SAMPLE_MAX_W'(1) << (slot_w + data_w - 1 - pos)));
    end
    return bit_v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_sck_gen.sv
`default_nettype none
// i2s_sck_gen -- programmable SCK divider with rise/fall event strobes.  rev 1.0
module i2s_sck_gen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] clk_div,
  output logic             sck,
  output logic             rise_en,
  output logic             fall_en
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             terminal;

  // Greater-or-equal so a divider lowered below the running count wraps at once.
  assign terminal = (cnt_q >= clk_div);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    sck_d = sck_q;
    if (!enable) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (terminal) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck     = sck_q;
  assign rise_en = enable && terminal && !sck_q;
  assign fall_en = enable && terminal && sck_q;

endmodule
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// i2s_tx -- stereo Philips I2S master transmitter with a one-entry sample buffer.  rev 1.0
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W = I2S_DATA_W,
  parameter int unsigned SLOT_W = I2S_SLOT_W,
  parameter int unsigned DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              sck,
  output logic              ws,
  output logic              sd,
  output logic              frame_start,
  output logic              underrun
);

  localparam int unsigned     FRAME_W  = 2 * SLOT_W;
  localparam int unsigned     BC_W     = $clog2(FRAME_W);
  localparam logic [BC_W-1:0] BC_LAST  = BC_W'(FRAME_W - 1);
  localparam logic [BC_W-1:0] WS_FIRST = BC_W'(SLOT_W - WS_LEAD);
  localparam logic [BC_W-1:0] WS_LAST  = BC_W'(FRAME_W - 1 - WS_LEAD);

  logic                    rise_en, fall_en;
  logic                    buf_full_q, buf_full_d;
  logic [DATA_W-1:0]       left_q, left_d;
  logic [DATA_W-1:0]       right_q, right_d;
  logic [BC_W-1:0]         bc_q, bc_d;
  logic [FRAME_W-1:0]      shift_q, shift_d;
  logic                    sd_q, sd_d;
  logic                    ws_q, ws_d;
  logic                    frame_start_q, frame_start_d;
  logic                    underrun_q, underrun_d;
  logic [SAMPLE_MAX_W-1:0] left_ext, right_ext;
  logic [FRAME_W-1:0]      buf_frame;

  i2s_sck_gen #(
    .DIV_W (DIV_W)
  ) u_sck_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .clk_div (clk_div),
    .sck     (sck),
    .rise_en (rise_en),
    .fall_en (fall_en)
  );

  assign left_ext  = SAMPLE_MAX_W'(left_q);
  assign right_ext = SAMPLE_MAX_W'(right_q);

  generate
    for (genvar i = 0; i < FRAME_W; i++) begin : g_frame
      assign buf_frame[i] = frame_bit(left_ext, right_ext, DATA_W, SLOT_W, i);
    end
  endgenerate

  // The shift register advances on SCK rise so its bit 0 is already the
  // next bit when the following fall drives sd.
  always_comb begin
    buf_full_d    = buf_full_q;
    left_d        = left_q;
    right_d       = right_q;
    bc_d          = bc_q;
    shift_d       = shift_q;
    sd_d          = sd_q;
    ws_d          = ws_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;

    if (s_valid && !buf_full_q) begin
      buf_full_d = 1'b1;
      left_d     = s_left;
      right_d    = s_right;
    end

    if (!enable) begin
      bc_d    = BC_LAST;
      shift_d = '0;
      sd_d    = 1'b0;
      ws_d    = 1'b0;
    end else if (rise_en) begin
      shift_d = shift_q >> 1;
    end else if (fall_en) begin
      if (bc_q == BC_LAST) begin
        bc_d          = '0;
        frame_start_d = 1'b1;
        if (buf_full_q) begin
          shift_d    = buf_frame;
          buf_full_d = 1'b0;
        end else begin
          shift_d    = '0;
          underrun_d = 1'b1;
        end
        sd_d = buf_full_q & buf_frame[0];
      end else begin
        bc_d = bc_q + 1'b1;
        sd_d = shift_q[0];
      end
      ws_d = (bc_d >= WS_FIRST) && (bc_d <= WS_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      buf_full_q    <= 1'b0;
      left_q        <= '0;
      right_q       <= '0;
      bc_q          <= BC_LAST;
      shift_q       <= '0;
      sd_q          <= 1'b0;
      ws_q          <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      buf_full_q    <= buf_full_d;
      left_q        <= left_d;
      right_q       <= right_d;
      bc_q          <= bc_d;
      shift_q       <= shift_d;
      sd_q          <= sd_d;
      ws_q          <= ws_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign s_ready     = ~buf_full_q;
  assign sd          = sd_q;
  assign ws          = ws_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// tb_i2s_tx -- directed self-checking bench for i2s_tx (DATA_W=24, SLOT_W=32).  rev 1.0
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [7:0]  clk_div;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_left;
  logic [23:0] s_right;
  logic        sck;
  logic        ws;
  logic        sd;
  logic        frame_start;
  logic        underrun;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int bp_n   = 0;
  bit bp_mode = 1'b0;

  localparam logic [63:0] EXP_WS = 64'h7FFF_FFFF_8000_0000;

  i2s_tx #(
    .DATA_W (24),
    .SLOT_W (32),
    .DIV_W  (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .clk_div     (clk_div),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_left      (s_left),
    .s_right     (s_right),
    .sck         (sck),
    .ws          (ws),
    .sd          (sd),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs and samples settle 1 time unit after the rising edge.
  task automatic tick();
    bit hs;
    hs = s_valid && s_ready;
    @(posedge clk);
    #1;
    if (hs) begin
      hs_cnt++;
      if (bp_mode) begin
        bp_n++;
        s_left  = 24'hA540C0 + 24'(bp_n);
        s_right = 24'h5A0300 + 24'(bp_n);
      end
    end
  endtask

  // Wire order: bit k of the result is the k-th bit sent in the frame.
  function automatic logic [63:0] exp_frame(input logic [23:0] l, input logic [23:0] r);
    logic [63:0] v;
    logic [23:0] lt, rt;
    v  = '0;
    lt = l;
    rt = r;
    for (int k = 0; k < 24; k++) begin
      v  = v | (64'(lt[23]) << k) | (64'(rt[23]) << (32 + k));
      lt = lt << 1;
      rt = rt << 1;
    end
    return v;
  endfunction

  // Called just after a frame wrap with clk_div=1; returns at the next wrap.
  task automatic run_frame(output logic [63:0] sdv, output logic [63:0] wsv,
                           output int fs, output int ur, output int hs, output bit sck_ok);
    int h0;
    h0 = hs_cnt;
    sdv = '0;
    wsv = '0;
    fs = 0;
    ur = 0;
    sck_ok = 1'b1;
    for (int k = 0; k < 64; k++) begin
      sdv = {sd, sdv[63:1]};
      wsv = {ws, wsv[63:1]};
      for (int j = 0; j < 4; j++) begin
        tick();
        if (!(k == 63 && j == 3)) begin
          fs += int'(frame_start);
          ur += int'(underrun);
        end
        if (sck !== ((j == 1) || (j == 2))) sck_ok = 1'b0;
      end
    end
    hs = hs_cnt - h0;
  endtask

  initial begin
    logic [63:0] sdv, wsv, dsd;
    int fs, ur, hs, n, k, since_fall, gap, last_gap, cyc;
    bit sck_ok, changed;
    logic prev;

    reset_n = 1'b0;
    enable  = 1'b1;
    clk_div = 8'd1;
    s_valid = 1'b0;
    s_left  = '0;
    s_right = '0;
    repeat (3) tick();
    chk("rst_sck", sck, 0);
    chk("rst_ws", ws, 0);
    chk("rst_sd", sd, 0);
    chk("rst_ready", s_ready, 1);
    chk("rst_fs", frame_start, 0);
    chk("rst_ur", underrun, 0);

    reset_n = 1'b1;
    s_valid = 1'b1;
    s_left  = 24'h800001;
    s_right = 24'h7FFFFF;
    tick();
    s_valid = 1'b0;
    chk("c1_ready", s_ready, 0);
    chk("c1_fs", frame_start, 0);
    tick();
    chk("c2_sck", sck, 1);
    tick();
    chk("c3_fs", frame_start, 0);
    tick();
    chk("c4_fs", frame_start, 1);
    chk("c4_ur", underrun, 0);
    chk("c4_sck", sck, 0);
    chk("c4_ready", s_ready, 1);

    run_frame(sdv, wsv, fs, ur, hs, sck_ok);
    chk("f1_sd", sdv, exp_frame(24'h800001, 24'h7FFFFF));
    chk("f1_ws", wsv, EXP_WS);
    chk("f1_fs", 64'(fs), 0);
    chk("f1_ur", 64'(ur), 0);
    chk("f1_sck", 64'(sck_ok), 1);
    chk("f2_start_fs", frame_start, 1);
    chk("f2_start_ur", underrun, 1);

    run_frame(sdv, wsv, fs, ur, hs, sck_ok);
    chk("f2_sd", sdv, 0);
    chk("f2_ur_inner", 64'(ur), 0);
    chk("f2_fs_inner", 64'(fs), 0);
    chk("f3_start_fs", frame_start, 1);
    chk("f3_start_ur", underrun, 1);

    bp_mode = 1'b1;
    bp_n    = 0;
    s_left  = 24'hA540C0;
    s_right = 24'h5A0300;
    s_valid = 1'b1;
    run_frame(sdv, wsv, fs, ur, hs, sck_ok);
    chk("f3_hs", 64'(hs), 1);
    chk("f3_sd", sdv, 0);
    chk("f4_start_ur", underrun, 0);
    run_frame(sdv, wsv, fs, ur, hs, sck_ok);
    chk("f4_sd", sdv, exp_frame(24'hA540C0, 24'h5A0300));
    chk("f4_hs", 64'(hs), 1);
    chk("f5_start_ur", underrun, 0);
    run_frame(sdv, wsv, fs, ur, hs, sck_ok);
    chk("f5_sd", sdv, exp_frame(24'hA540C1, 24'h5A0301));
    chk("f5_hs", 64'(hs), 1);

    // Frame 6 carries pair 2; pair 3 is captured on its first clock.
    tick();
    s_valid = 1'b0;
    bp_mode = 1'b0;
    repeat (69) tick();
    chk("bc17_sck", sck, 1);
    chk("bc17_sd", sd, 1);
    enable = 1'b0;
    tick();
    chk("drop_sck", sck, 0);
    chk("drop_ws", ws, 0);
    chk("drop_sd", sd, 0);
    chk("drop_ready", s_ready, 0);
    repeat (5) tick();
    chk("idle_fs", frame_start, 0);
    chk("idle_sck", sck, 0);

    enable = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < 20);
    chk("re_fs_latency", 64'(n), 4);
    chk("re_ur", underrun, 0);
    run_frame(sdv, wsv, fs, ur, hs, sck_ok);
    chk("re_sd", sdv, exp_frame(24'hA540C3, 24'h5A0303));
    chk("re_ws", wsv, EXP_WS);
    chk("re_next_ur", underrun, 1);

    enable  = 1'b0;
    clk_div = 8'd3;
    tick();
    s_valid = 1'b1;
    s_left  = 24'h13579B;
    s_right = 24'h2468AC;
    tick();
    s_valid = 1'b0;
    chk("div_push_ready", s_ready, 0);
    enable = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < 20);
    chk("div_fs_latency", 64'(n), 8);

    dsd = '0;
    dsd = {sd, dsd[63:1]};
    k = 1;
    prev = sck;
    since_fall = 0;
    gap = 0;
    last_gap = 0;
    changed = 1'b0;
    cyc = 0;
    while (k < 64 && cyc < 2000) begin
      tick();
      cyc++;
      since_fall++;
      gap++;
      if (sck !== prev) begin
        last_gap = gap;
        gap = 0;
        if (prev === 1'b1) begin
          dsd = {sd, dsd[63:1]};
          k++;
          since_fall = 0;
        end
      end
      prev = sck;
      if (!changed && k == 11 && since_fall == 6) begin
        clk_div = 8'd0;
        changed = 1'b1;
      end
    end
    chk("div_bits", 64'(k), 64);
    chk("div_sd", dsd, exp_frame(24'h13579B, 24'h2468AC));
    chk("div_half_period", 64'(last_gap), 1);

    s_valid = 1'b1;
    s_left  = 24'h111111;
    s_right = 24'h222222;
    tick();
    s_valid = 1'b0;
    chk("mid_push_ready", s_ready, 0);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_ready", s_ready, 1);
    chk("mid_rst_sck", sck, 0);
    chk("mid_rst_sd", sd, 0);
    reset_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < 20);
    chk("post_rst_latency", 64'(n), 2);
    chk("post_rst_ur", underrun, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_tx.md
# i2s_tx

Stereo I2S transmitter behind the I2S register block: accepts left/right sample pairs over a valid/ready handshake and serialises them as standard Philips I2S (SCK, WS, SD) in master mode. It holds a one-entry sample buffer and derives SCK from the system clock with a programmable divider. The register block's Avalon slave drives `clk_div` and `enable`, and pushes samples into it.

## Interface
- `DATA_W`, 24: sample width per channel; must be ≤ `SLOT_W`.
- `SLOT_W`, 32: SCK cycles per channel slot.
- `DIV_W`, 8: width of `clk_div`.

Ports:
- `clk` in 1: system clock; the only clock.
- `reset_n` in 1: reset, synchronous and active-low.
- `enable` in 1: run serialiser; low means idle.
- `clk_div` in `DIV_W`: SCK half-period minus one, in `clk` cycles.
- `s_valid` in 1: sample pair valid.
- `s_ready` out 1: buffer empty, can accept.
- `s_left` in `DATA_W`: left sample, two's complement.
- `s_right` in `DATA_W`: right sample.
- `sck` out 1: I2S bit clock.
- `ws` out 1: word select; 0 = left, 1 = right.
- `sd` out 1: serial data, MSB first.
- `frame_start` out 1: one-`clk` pulse when a new frame begins.
- `underrun` out 1: one-`clk` pulse when a frame begins with an empty buffer.

## Operation
- Reset (`reset_n`=0 at a `clk` edge) outputs: `sck`=0, `ws`=0, `sd`=0, `s_ready`=1, `frame_start`=0, `underrun`=0.
- Reset internal state:
  - buffer empty; divider count 0.
  - bit count `bc` = 2·`SLOT_W`−1.
  - shift register all zero.
- **Divider:**
  - Counts 0..`clk_div`; at the terminal count it wraps and `sck` toggles. Half-period = `clk_div`+1 clocks; `clk_div`=0 gives `clk`/2.
  - `clk_div` is compared live, so a change takes effect within the current half-period.
- **Falling-edge event** (the `sck` 1→0 toggle), all in the same `clk` edge:
  - `bc` increments modulo 2·`SLOT_W`.
  - `sd` and `ws` update.
- **Frame wrap** (`bc` becomes 0):
  - If the buffer is full: load the 2·`SLOT_W` frame {`s_left`, zero pad, `s_right`, zero pad} (each sample MSB-justified in its slot); buffer becomes empty.
  - If the buffer is empty: load all zeros and pulse `underrun`.
  - Pulse `frame_start` in either case.
- **Bit mapping:**
  - `sd` = frame bit `bc`, with bit 0 = left MSB.
  - `ws` = 1 for `bc` in [`SLOT_W`−1, 2·`SLOT_W`−2], else 0. WS therefore leads each channel's MSB by one SCK, per I2S.
- **Buffer:**
  - `s_ready` = buffer empty (registered).
  - Transfer on `s_valid`&&`s_ready` at a `clk` edge: sample pair captured, `s_ready` low from the next cycle.
  - A load at frame wrap empties the buffer; `s_ready` returns high the cycle after. A handshake and a load never coincide.
- **`enable`=0:**
  - Immediately forces the idle state: `sck`=0, `ws`=0, `sd`=0, divider count 0, `bc`=2·`SLOT_W`−1.
  - Buffer content is kept; a mid-frame deassert abandons the frame.
- **Restart:** after `enable` rises, the first SCK rising toggle is `clk_div`+1 clocks later. The first falling toggle, `clk_div`+1 clocks after that, is frame wrap.
- Reset mid-frame: same as reset; the buffered sample is discarded.

## Timing
- SCK period = 2(`clk_div`+1) clocks; frame = 2·`SLOT_W` SCK periods.
- `sck`, `ws`, `sd`, `frame_start` and `underrun` are all registered.
- `ws`/`sd` change on the same `clk` edge as `sck` falls, so the receiver samples on SCK rise with a full half-period of setup.
- Enable-to-first-`frame_start`: 2(`clk_div`+1) clocks.
- A sample accepted at least one `clk` before frame wrap is emitted in that frame. Otherwise it is emitted in the next frame.

## Structure
- Package `i2s_pkg`:
  - `SLOT_W` default and `DATA_W` default.
  - The frame-layout function (sample pair → 2·`SLOT_W` frame).
  - WS-window constants.
- Sub-module `i2s_sck_gen`: divider counter plus `sck` toggle. Outputs `sck` and the `rise_en`/`fall_en` strobes; `enable` and `clk_div` are inputs.
- The top level holds the buffer, `bc`, the shift register and the event pulses.

## Test plan
All scenarios use `DATA_W`=24, `SLOT_W`=32.
- **Reset:** `reset_n`=0 with `enable`=1 → all outputs at reset values, `s_ready`=1. After release with `clk_div`=1, `frame_start` occurs at clock 4 and `sck` has period 4.
- **Single frame:** push left=0x800001, right=0x7FFFFF before the first wrap.
  - `sd` over bits 0..63 = 1, 22×0, 1, 8×0, 0, 23×1, 8×0.
  - `ws` = 0 for `bc` 0..30 and 63, 1 for `bc` 31..62.
  - No `underrun`.
- **Underrun:** push no sample → frame all zeros, `underrun` pulses once per frame, `frame_start` every 256 clocks (`clk_div`=1).
- **Back-pressure:** hold `s_valid`=1 with an incrementing pair → `s_ready` high for exactly one handshake per frame, each pair emitted exactly once, in order.
- **Enable drop:** drop `enable` at `bc`=17 → next clock `sck`=`ws`=`sd`=0, buffered pair retained. On re-enable that pair is emitted in the first frame.
- **Divider change:** change `clk_div` 3→0 mid-frame → SCK half-period becomes 1 clock from the next toggle. The bit sequence is unbroken.
